hamming_encoder: RTL and testbench

HAMMING_ENCODER -- requirements
Module: hamming_encoder

---
 rtl/hamming_encoder.sv | 103 ++++++++++
 tb/tb_hamming_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder.sv
// Byte-to-two-codeword Hamming(7,4)+overall-parity encoder with optional fault injection.
// Each accepted byte yields the low-nibble codeword, then the high-nibble codeword.
module hamming_encoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         inj_mode,
  input  logic [2:0]         inj_pos,
  output logic [7:0]         out_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e             r_state;
  logic [7:0]         r_byte;
  logic [1:0]         r_mode;
  logic [2:0]         r_pos;
  logic [7:0]         r_code;
  logic [COUNT_W-1:0] r_count;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_take;
  logic [7:0] w_lo_code;
  logic [7:0] w_hi_code;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic c0, c1, c2;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[1] ^ d[2] ^ d[3];
    return {c0 ^ c1 ^ c2 ^ (^d), d[3], d[2], d[1], c2, d[0], c1, c0};
  endfunction

  function automatic logic [7:0] inject(input logic [7:0] c, input logic [1:0] m,
                                        input logic [2:0] p);
    logic [7:0] mask;
    mask = 8'h00;
    case (m)
      2'b01:   mask = 8'h01 << p;
      // Second flip wraps from bit 7 to bit 0 through the 3-bit add.
      2'b10:   mask = (8'h01 << p) | (8'h01 << (p + 3'd1));
      default: mask = 8'h00;
    endcase
    return c ^ mask;
  endfunction

  always_comb begin
    w_out_valid = (r_state != StIdle);
    w_in_ready  = (r_state == StIdle) || ((r_state == StHi) && out_ready);
    w_take      = in_valid && w_in_ready;
    w_lo_code   = inject(enc(in_data[3:0]), inj_mode, inj_pos);
    w_hi_code   = inject(enc(r_byte[7:4]), r_mode, r_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_byte  <= 8'h00;
      r_mode  <= 2'b00;
      r_pos   <= 3'd0;
      r_code  <= 8'h00;
      r_count <= '0;
    end else begin
      if (w_out_valid && out_ready) begin
        r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      if (w_take) begin
        r_byte  <= in_data;
        r_mode  <= inj_mode;
        r_pos   <= inj_pos;
        r_code  <= w_lo_code;
        r_state <= StLo;
      end else begin
        case (r_state)
          StLo: begin
            if (out_ready) begin
              r_code  <= w_hi_code;
              r_state <= StHi;
            end
          end
          StHi: begin
            if (out_ready) r_state <= StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_code  = r_code;
  assign cw_count  = r_count;

endmodule

// File: tb/tb_hamming_encoder.sv
// Randomized and directed checks of hamming_encoder against a queue-based reference model.
module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready4;
  logic [1:0]  inj_mode = 2'b00;
  logic [2:0]  inj_pos = 3'd0;
  logic [7:0]  out_code, out_code4;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b1;
  logic [15:0] cw_count;
  logic [3:0]  cw_count4;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_q[$];
  logic [15:0] m_cnt = 16'd0;

  always #5 clk = ~clk;

  hamming_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inj_mode(inj_mode), .inj_pos(inj_pos), .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .cw_count(cw_count)
  );

  hamming_encoder #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .inj_mode(inj_mode), .inj_pos(inj_pos), .out_code(out_code4), .out_valid(out_valid4),
    .out_ready(out_ready), .cw_count(cw_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Classic Hamming: 1-based position i holds data unless i is a power of two;
  // parity at 2^k covers every position whose index has bit k set.
  function automatic logic [7:0] ref_code(input logic [3:0] d, input logic [1:0] m,
                                          input logic [2:0] p);
    logic [7:0] c;
    logic       par;
    int         di;
    c  = 8'h00;
    di = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i != 1 && i != 2 && i != 4) begin
        c[i-1] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int i = 1; i <= 7; i++) if ((i & (1 << k)) != 0) par ^= c[i-1];
      c[(1 << k) - 1] = par;
    end
    c[7] = ^c[6:0];
    if (m == 2'b01) c[p] = ~c[p];
    if (m == 2'b10) begin
      c[p] = ~c[p];
      c[(int'(p) + 1) % 8] = ~c[(int'(p) + 1) % 8];
    end
    return c;
  endfunction

  // Model: pending codewords of the current byte; empty means idle.
  always @(negedge clk) begin
    logic exp_ready;
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 16'd0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_code", out_code, 8'h00);
      check("rst_cw_count", cw_count, 16'd0);
      check("rst_cw_count4", cw_count4, 4'd0);
    end else begin
      exp_ready = (m_q.size() == 0) || (m_q.size() == 1 && out_ready);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("out_code", out_code, m_q[0]);
      check("cw_count", cw_count, m_cnt);
      check("cw_count4", cw_count4, m_cnt[3:0]);
      if (m_q.size() != 0 && out_ready) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (in_valid && exp_ready) begin
        m_q.push_back(ref_code(in_data[3:0], inj_mode, inj_pos));
        m_q.push_back(ref_code(in_data[7:4], inj_mode, inj_pos));
      end
    end
  end

  task automatic put(input logic [7:0] d, input logic [1:0] m, input logic [2:0] p);
    in_data  = d;
    inj_mode = m;
    inj_pos  = p;
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 59) check("put_timeout", 1'b0, 1'b1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    inj_mode = 2'($urandom);
    inj_pos  = 3'($urandom);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Nominal byte, then both injection modes.
    put(8'hB1, 2'b00, 3'd0);
    cycles(2);
    check("b1_count", cw_count, 16'd2);
    put(8'hB1, 2'b01, 3'd0);
    cycles(2);
    put(8'hB1, 2'b10, 3'd7);
    cycles(2);

    // Back-to-back bytes.
    put(8'h00, 2'b00, 3'd0);
    put(8'hFF, 2'b00, 3'd0);
    cycles(3);

    // Stall in LO while upstream keeps changing.
    put(8'hB1, 2'b00, 3'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data  = 8'($urandom);
      inj_mode = 2'($urandom);
      cycles(1);
    end
    check("stall_code", out_code, 8'h87);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(3);

    // Reset while in HI, then a fresh byte.
    put(8'hB1, 2'b00, 3'd0);
    cycles(1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_code", out_code, 8'h00);
    cycles(1);
    rst_n = 1'b1;
    put(8'h0F, 2'b00, 3'd0);
    cycles(3);

    // Narrow counter wraps after 16 handshakes.
    do_reset();
    for (int i = 0; i < 8; i++) put(8'($urandom), 2'b00, 3'd0);
    cycles(3);
    check("wrap4", cw_count4, 4'd0);
    check("count16", cw_count, 16'd16);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      inj_mode  = 2'($urandom);
      inj_pos   = 3'($urandom);
      rst_n     = ($urandom_range(199) != 0);
      cycles(1);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycles(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
